// File: rtl/qam_fs4_mixer.sv
// fs/4 quadrature mixer: upconverts baseband I/Q to a real passband and downconverts a real channel back to I/Q.
// Define QAM_FS4_MIXER_SAT_EN to clamp negation/shift overflow; by default results wrap two's-complement.
module qam_fs4_mixer #(
   parameter int WIDTH     = 18,
   parameter int I_DELAY   = 1,
   parameter int TX_SHIFT  = 1,
   parameter int HOLD_MODE = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear_accum,
   input  logic signed [WIDTH-1:0] tx_i,
   input  logic signed [WIDTH-1:0] tx_q,
   input  logic signed [WIDTH-1:0] rx_in,
   output logic signed [WIDTH-1:0] up_out,
   output logic signed [WIDTH-1:0] dn_i,
   output logic signed [WIDTH-1:0] dn_q,
   output logic                    dn_valid_i,
   output logic                    dn_valid_q,
   output logic [1:0]              phase
);

   // state | meaning
   // PH_0  | LO = +1 on I: up_out <- i_d,  dn_i <- +rx_in
   // PH_1  | LO = -1 on Q: up_out <- -tx_q, dn_q <- -rx_in
   // PH_2  | LO = -1 on I: up_out <- -i_d, dn_i <- -rx_in
   // PH_3  | LO = +1 on Q: up_out <- tx_q,  dn_q <- +rx_in
   typedef enum logic [1:0] {
      PH_0 = 2'd0,
      PH_1 = 2'd1,
      PH_2 = 2'd2,
      PH_3 = 2'd3
   } phase_t;

   phase_t state_q;
   phase_t state_d;

   logic                    restart;
   logic signed [WIDTH-1:0] i_d;
   logic signed [WIDTH-1:0] up_d;
   logic signed [WIDTH-1:0] dn_i_d;
   logic signed [WIDTH-1:0] dn_q_d;
   logic                    valid_i_d;
   logic                    valid_q_d;

   // Reset and clear have the same end state, so one restart term serves both.
   assign restart = reset | clear_accum;

`ifdef QAM_FS4_MIXER_SAT_EN
   localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH+1:0] MAX_EXT = {3'b000, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH+1:0] MIN_EXT = {3'b111, {(WIDTH-1){1'b0}}};

   function automatic logic signed [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] x);
      return (x == MIN_VAL) ? MAX_VAL : -x;
   endfunction

   function automatic logic signed [WIDTH-1:0] shift_out(input logic signed [WIDTH-1:0] x);
      logic signed [WIDTH+1:0] ext;
      ext = {{2{x[WIDTH-1]}}, x};
      ext = ext <<< TX_SHIFT;
      if (ext > MAX_EXT)
         return MAX_VAL;
      else if (ext < MIN_EXT)
         return MIN_VAL;
      else
         return ext[WIDTH-1:0];
   endfunction
`else
   function automatic logic signed [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] x);
      return -x;
   endfunction

   function automatic logic signed [WIDTH-1:0] shift_out(input logic signed [WIDTH-1:0] x);
      return x <<< TX_SHIFT;
   endfunction
`endif

   always_ff @(posedge clk) begin
      if (restart)
         state_q <= PH_0;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         PH_0:    state_d = PH_1;
         PH_1:    state_d = PH_2;
         PH_2:    state_d = PH_3;
         PH_3:    state_d = PH_0;
         default: state_d = PH_0;
      endcase
   end

   assign phase = state_q;

   generate
      if (I_DELAY == 0) begin : g_no_dly
         assign i_d = tx_i;
      end else begin : g_dly
         logic signed [WIDTH-1:0] dly [I_DELAY];

         always_ff @(posedge clk) begin
            if (restart) begin
               for (int k = 0; k < I_DELAY; k++)
                  dly[k] <= '0;
            end else begin
               dly[0] <= tx_i;
               for (int k = 1; k < I_DELAY; k++)
                  dly[k] <= dly[k-1];
            end
         end

         assign i_d = dly[I_DELAY-1];
      end
   endgenerate

   always_comb begin
      up_d      = '0;
      dn_i_d    = (HOLD_MODE != 0) ? dn_i : '0;
      dn_q_d    = (HOLD_MODE != 0) ? dn_q : '0;
      valid_i_d = 1'b0;
      valid_q_d = 1'b0;
      case (state_q)
         PH_0: begin
            up_d      = shift_out(i_d);
            dn_i_d    = rx_in;
            valid_i_d = 1'b1;
         end
         PH_1: begin
            up_d      = shift_out(negate(tx_q));
            dn_q_d    = negate(rx_in);
            valid_q_d = 1'b1;
         end
         PH_2: begin
            up_d      = shift_out(negate(i_d));
            dn_i_d    = negate(rx_in);
            valid_i_d = 1'b1;
         end
         PH_3: begin
            up_d      = shift_out(tx_q);
            dn_q_d    = rx_in;
            valid_q_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (restart) begin
         up_out     <= '0;
         dn_i       <= '0;
         dn_q       <= '0;
         dn_valid_i <= 1'b0;
         dn_valid_q <= 1'b0;
      end else begin
         up_out     <= up_d;
         dn_i       <= dn_i_d;
         dn_q       <= dn_q_d;
         dn_valid_i <= valid_i_d;
         dn_valid_q <= valid_q_d;
      end
   end

endmodule

// File: doc/qam_fs4_mixer.md
QAM_FS4_MIXER -- requirements
Module: qam_fs4_mixer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 18, giving the signed sample width of all data ports.
REQ-002 The block SHALL have parameter I_DELAY, default 1, range 0..3, giving the I-path alignment delay in clocks.
REQ-003 The block SHALL have parameter TX_SHIFT, default 1, range 0..2, giving the arithmetic left shift applied to up_out.
REQ-004 The block SHALL have parameter HOLD_MODE, default 0: 0 zero-stuffs dn_i/dn_q on non-owning phases, 1 holds the last value.
REQ-005 The block SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-007 The block SHALL have port clear_accum, input, 1, a synchronous restart of phase and datapath.
REQ-008 The block SHALL have port tx_i, input, WIDTH signed, the baseband I sample.
REQ-009 The block SHALL have port tx_q, input, WIDTH signed, the baseband Q sample.
REQ-010 The block SHALL have port rx_in, input, WIDTH signed, the real passband channel sample.
REQ-011 The block SHALL have port up_out, output, WIDTH signed, the registered fs/4 upconverted passband.
REQ-012 The block SHALL have port dn_i, output, WIDTH signed, the registered downconverted I.
REQ-013 The block SHALL have port dn_q, output, WIDTH signed, the registered downconverted Q.
REQ-014 The block SHALL have port dn_valid_i, output, 1, which is high for one cycle when dn_i carries a new sample.
REQ-015 The block SHALL have port dn_valid_q, output, 1, which is high for one cycle when dn_q carries a new sample.
REQ-016 The block SHALL have port phase, output, 2, the current NCO phase count.

Function
REQ-017 The phase counter SHALL be 2 bits, SHALL increment by 1 every clock, and SHALL wrap from 3 to 0.
REQ-018 The I delay line SHALL be I_DELAY registers deep on tx_i; i_d SHALL equal tx_i delayed I_DELAY clocks, and when I_DELAY=0, i_d SHALL equal tx_i.
REQ-019 The upconverter SHALL register up_out at each edge from the current phase: phase 0 gives i_d, 1 gives -tx_q, 2 gives -i_d, 3 gives tx_q, then the result is shifted left by TX_SHIFT; latency is 1 clock.
REQ-020 The downconverter SHALL capture at each edge using the current phase: phase 0 sets dn_i to rx_in, phase 2 sets dn_i to -rx_in, phase 1 sets dn_q to -rx_in, phase 3 sets dn_q to rx_in.
REQ-021 On non-owning phases, dn_i and dn_q SHALL be 0 when HOLD_MODE=0 and SHALL keep their previous value when HOLD_MODE=1.
REQ-022 dn_valid_i SHALL be registered high after a phase 0 or phase 2 capture, and dn_valid_q after a phase 1 or phase 3 capture; each is 1 clock wide and the two never assert together.
REQ-023 The phase output SHALL equal the counter value used by the next capture.
REQ-024 Negation of the most-negative value and left-shift overflow SHALL follow the Configuration section.
REQ-025 When clear_accum is high, the block SHALL load phase 0, clear the delay line, clear all outputs and clear both valid flags on that edge; the next edge processes phase 0.
REQ-026 When reset and clear_accum are both high, reset SHALL take priority; the end state is identical.

Reset
REQ-027 While reset is high at an edge, phase, the delay line, up_out, dn_i, dn_q, dn_valid_i and dn_valid_q SHALL all be 0.
REQ-028 The first edge after reset deasserts SHALL process phase 0.
REQ-029 Asserting reset mid-stream SHALL discard all in-flight delay-line data with no residual output.

Configuration
REQ-030 The macro QAM_FS4_MIXER_SAT_EN SHALL control overflow handling in negation and shift.
REQ-031 When QAM_FS4_MIXER_SAT_EN is defined, results SHALL clamp to +(2^(WIDTH-1)-1) and -2^(WIDTH-1); negating -2^(WIDTH-1) SHALL give +(2^(WIDTH-1)-1).
REQ-032 When QAM_FS4_MIXER_SAT_EN is not defined, results SHALL wrap two's-complement, dropping MSBs; negating -2^(WIDTH-1) SHALL return -2^(WIDTH-1).

Verification
REQ-033 With defaults, reset for 2 clocks then released: phase reads 0,1,2,3,0 on successive clocks and all outputs are 0 during reset.
REQ-034 With defaults, tx_i=1000 and tx_q=500 held constant: steady-state up_out cycles 2000, -1000, -2000, 1000.
REQ-035 With rx_in=300 constant and HOLD_MODE=0: dn_i sequence is 300, 0, -300, 0 and dn_q sequence is 0, -300, 0, 300, with valids alternating i, q, i, q.
REQ-036 With HOLD_MODE=1 and the same stimulus: dn_i holds 300 through the phase 1 capture and dn_q holds -300 through the phase 2 capture.
REQ-037 With tx_i=-131072 and WIDTH=18: up_out saturates to 131071 at phase 2 with SAT_EN defined, and wraps to 0 with SAT_EN undefined.
REQ-038 Pulsing clear_accum at phase 2 mid-stream: the next phase is 0, outputs are 0 for 1 clock, and with I_DELAY=1 the cleared delay register is reflected in the first new up_out.
